arpeggiator_n: RTL and testbench
================================

Name: arpeggiator_n

Overview:
Parametrised N-key arpeggiator; successor to the fixed 4-key arpeggiator in the voice front end. Sits between key scanning and the voice allocator. When enabled it cycles through the currently held keys one at a time in up, down, ping-pong or (optionally) random order. Each note lasts a programmable step length and sounds for a programmable gate length. When disabled it passes keys straight through.

Parameters:
NUM_KEYS, 8, number of key inputs/outputs (2..32)
CNT_W, 16, width of step/gate counters
IDX_W, $clog2(NUM_KEYS), width of current-index output

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
enable  in  1  1 = arpeggiate, 0 = bypass
mode  in  2  0 = up, 1 = down, 2 = ping-pong, 3 = random (see Optional Feature)
step_len  in  CNT_W  cycles per step minus 1
gate_len  in  CNT_W  cycles key_on is high within a step
keys  in  NUM_KEYS  held-key vector, bit i = key i
key_on  out  NUM_KEYS  registered note-on vector to voice allocator
step_pulse  out  1  one-cycle strobe at each step start
cur_idx  out  IDX_W  index of current arpeggiated key
active  out  1  high in PLAY state

Behaviour:
- Reset: every output 0. State = BYPASS, counter = 0, idx = 0, dir = up. LFSR = 16'hACE1.
- States: BYPASS, IDLE, PLAY. All outputs are registered; each responds 1 cycle after its inputs.
- BYPASS: key_on <= keys. Exit to IDLE when enable = 1.
- Any state: if enable = 0, go to BYPASS next cycle; counter and dir are cleared.
- IDLE (enabled, keys == 0): key_on = 0.
- IDLE -> PLAY when keys != 0:
  - idx = lowest held key for up, ping-pong and random; highest held key for down.
  - counter = 0, step_pulse = 1.
- PLAY:
  - counter increments each cycle.
  - When counter == step_len: counter <= 0, idx <= next(idx), step_pulse = 1.
  - step_len = 0 advances every cycle.
- Gate: key_on = onehot(idx) while counter < gate_len and keys[idx] = 1; otherwise 0.
  - gate_len = 0 means silent.
  - gate_len > step_len means legato (no gap).
- next(idx), searching only held keys:
  - up: next higher held key, wrapping to lowest.
  - down: next lower held key, wrapping to highest.
  - ping-pong: move in dir. If no held key exists in dir, flip dir and take the nearest held key the other way. Endpoints are not repeated.
  - Single held key: idx unchanged, but the step is re-triggered (step_pulse fires, gate restarts).
- Current key released mid-step (keys[idx] = 0, others held): key_on[idx] drops next cycle, and a step boundary is forced the same cycle (counter <= 0, advance, step_pulse).
- keys goes to 0 in PLAY: go to IDLE next cycle, key_on = 0, dir = up.
- mode, step_len and gate_len are sampled continuously. A mode change takes effect at the next boundary; no restart.
- Held keys added mid-step join the order at the next boundary.
- Simultaneous release of the current key and a step_len match: a single advance occurs.

Optional Feature:
Macro ARP_RANDOM_EN.
- Defined: 16-bit Galois LFSR (taps 16,14,13,11) steps on every step_pulse. mode 3 selects the held key at position (lfsr mod popcount(keys)) in ascending order.
- Undefined: no LFSR is built, and mode 3 behaves exactly as mode 0 (up).

Test Plan:
- RESET then enable = 0, keys = 8'b0000_0101 -> key_on = 8'b0000_0101 one cycle later; active = 0.
- enable = 1, mode = 0, step_len = 3, gate_len = 2, keys = 8'b1001_0010 -> cur_idx sequence 1, 4, 7, 1 every 4 cycles. key_on high for 2 of every 4 cycles. step_pulse every 4th cycle.
- mode = 2, step_len = 0, keys = 8'b0000_1111 -> cur_idx 0, 1, 2, 3, 2, 1, 0, 1 on consecutive cycles.
- mode = 1, step_len = 9, keys = 8'b0011_0000, release key 5 at counter = 4 -> key_on[5] falls next cycle, forced step to idx 4, step_pulse pulses once.
- In PLAY, drop keys to 0 then drop enable -> IDLE with key_on = 0 in 1 cycle; BYPASS the next cycle; assert RESET mid-step -> all outputs 0 next cycle.
- With ARP_RANDOM_EN, mode = 3, keys = 8'hFF, step_len = 0 -> 64 steps each select only held keys, and every index 0..7 is hit. Without the macro, the same stimulus gives the up sequence.

Source files
------------

// File: rtl/arpeggiator_n.sv
// N-key arpeggiator: plays held keys one at a time (up/down/ping-pong/random) or passes keys through; all outputs registered.
// Define ARP_RANDOM_EN to build the LFSR random order; without it mode 3 plays as up.
module arpeggiator_n #(
  parameter int NUM_KEYS = 8,
  parameter int CNT_W    = 16,
  parameter int IDX_W    = $clog2(NUM_KEYS)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [CNT_W-1:0]    step_len,
  input  logic [CNT_W-1:0]    gate_len,
  input  logic [NUM_KEYS-1:0] keys,
  output logic [NUM_KEYS-1:0] key_on,
  output logic                step_pulse,
  output logic [IDX_W-1:0]    cur_idx,
  output logic                active
);

  typedef enum logic [1:0] {
    ST_BYPASS = 2'd0,
    ST_IDLE   = 2'd1,
    ST_PLAY   = 2'd2
  } state_t;

  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_PP   = 2'd2;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                dir_dn_q, dir_dn_d;
  logic [NUM_KEYS-1:0] key_on_q, key_on_d;
  logic                pulse_q, pulse_d;
  logic                active_q, active_d;

  logic                up_found, dn_found;
  logic [IDX_W-1:0]    up_idx, dn_idx, lo_idx, hi_idx, adv_idx;
  logic                adv_dir_dn;

  function automatic logic [IDX_W-1:0] lowest_of(input logic [NUM_KEYS-1:0] k);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (k[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] highest_of(input logic [NUM_KEYS-1:0] k);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (k[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // {found, index} of the nearest held key strictly above idx
  function automatic logic [IDX_W:0] above_of(input logic [NUM_KEYS-1:0] k,
                                              input logic [IDX_W-1:0]    idx);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (k[i] && (i > int'(idx))) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  function automatic logic [IDX_W:0] below_of(input logic [NUM_KEYS-1:0] k,
                                              input logic [IDX_W-1:0]    idx);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (k[i] && (i < int'(idx))) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  always_comb begin
    {up_found, up_idx} = above_of(keys, idx_q);
    {dn_found, dn_idx} = below_of(keys, idx_q);
    lo_idx             = lowest_of(keys);
    hi_idx             = highest_of(keys);
  end

`ifdef ARP_RANDOM_EN
  localparam logic [1:0] MODE_RAND = 2'd3;

  logic [15:0]      lfsr_q, lfsr_d;
  logic [IDX_W-1:0] rand_idx;

  // Held key at ascending position (r mod popcount)
  function automatic logic [IDX_W-1:0] pick_nth(input logic [NUM_KEYS-1:0] k,
                                                input logic [15:0]         r);
    int               pop;
    int               tgt;
    int               seen;
    logic [IDX_W-1:0] res;
    pop  = 0;
    seen = 0;
    res  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (k[i]) pop++;
    end
    tgt = (pop == 0) ? 0 : (int'(r) % pop);
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (k[i]) begin
        if (seen == tgt) res = IDX_W'(i);
        seen++;
      end
    end
    return res;
  endfunction

  assign rand_idx = pick_nth(keys, lfsr_q);

  always_comb begin
    lfsr_d = lfsr_q;
    if (pulse_d) lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge CLK) begin
    if (RESET) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
`endif

  // Index and direction taken at the next step boundary
  always_comb begin
    adv_idx    = up_found ? up_idx : lo_idx;
    adv_dir_dn = dir_dn_q;
    case (mode)
      MODE_DOWN: adv_idx = dn_found ? dn_idx : hi_idx;
      MODE_PP: begin
        if (!dir_dn_q) begin
          if (up_found) begin
            adv_idx = up_idx;
          end else begin
            adv_dir_dn = 1'b1;
            adv_idx    = dn_found ? dn_idx : idx_q;
          end
        end else begin
          if (dn_found) begin
            adv_idx = dn_idx;
          end else begin
            adv_dir_dn = 1'b0;
            adv_idx    = up_found ? up_idx : idx_q;
          end
        end
      end
`ifdef ARP_RANDOM_EN
      MODE_RAND: adv_idx = rand_idx;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    dir_dn_d = dir_dn_q;
    pulse_d  = 1'b0;
    key_on_d = '0;

    if (!enable) begin
      state_d  = ST_BYPASS;
      cnt_d    = '0;
      dir_dn_d = 1'b0;
    end else begin
      case (state_q)
        ST_BYPASS: state_d = ST_IDLE;
        ST_IDLE: begin
          if (|keys) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
            idx_d   = (mode == MODE_DOWN) ? hi_idx : lo_idx;
            pulse_d = 1'b1;
          end
        end
        ST_PLAY: begin
          if (keys == '0) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            dir_dn_d = 1'b0;
          // >= also ends a step promptly if step_len is lowered below the running count
          end else if (!keys[idx_q] || (cnt_q >= step_len)) begin
            cnt_d    = '0;
            idx_d    = adv_idx;
            dir_dn_d = adv_dir_dn;
            pulse_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_BYPASS;
      endcase
    end

    if (state_d == ST_BYPASS) begin
      key_on_d = keys;
    end else if ((state_d == ST_PLAY) && (cnt_d < gate_len) && keys[idx_d]) begin
      key_on_d = NUM_KEYS'(1) << idx_d;
    end
    active_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_BYPASS;
      cnt_q    <= '0;
      idx_q    <= '0;
      dir_dn_q <= 1'b0;
      key_on_q <= '0;
      pulse_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      dir_dn_q <= dir_dn_d;
      key_on_q <= key_on_d;
      pulse_q  <= pulse_d;
      active_q <= active_d;
    end
  end

  assign key_on     = key_on_q;
  assign step_pulse = pulse_q;
  assign cur_idx    = idx_q;
  assign active     = active_q;

endmodule

// File: tb/tb_arpeggiator_n.sv
// Bench for arpeggiator_n: directed test-plan steps, then random keys/modes, all checked
// each cycle against a reference model built on sorted held-key lists.
module tb_arpeggiator_n;

  localparam int NK = 8;
  localparam int CW = 16;
  localparam int IW = 3;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          enable;
  logic [1:0]    mode;
  logic [CW-1:0] step_len;
  logic [CW-1:0] gate_len;
  logic [NK-1:0] keys;
  logic [NK-1:0] key_on;
  logic          step_pulse;
  logic [IW-1:0] cur_idx;
  logic          active;

  int n_assert = 0;
  int n_fail   = 0;

  arpeggiator_n #(.NUM_KEYS(NK), .CNT_W(CW), .IDX_W(IW)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .enable     (enable),
    .mode       (mode),
    .step_len   (step_len),
    .gate_len   (gate_len),
    .keys       (keys),
    .key_on     (key_on),
    .step_pulse (step_pulse),
    .cur_idx    (cur_idx),
    .active     (active)
  );

  always #5 CLK = ~CLK;

  // Reference model
  localparam int M_BYP  = 0;
  localparam int M_IDLE = 1;
  localparam int M_PLAY = 2;

  int            m_state = M_BYP;
  int            m_cnt   = 0;
  int            m_idx   = 0;
  bit            m_down  = 1'b0;
  logic [15:0]   m_lfsr  = 16'hACE1;
  logic [NK-1:0] m_key_on = '0;
  bit            m_pulse = 1'b0;
  int            held[$];

  function automatic int first_above(int idx);
    int r;
    r = -1;
    for (int j = held.size() - 1; j >= 0; j--) begin
      if (held[j] > idx) r = held[j];
    end
    return r;
  endfunction

  function automatic int last_below(int idx);
    int r;
    r = -1;
    for (int j = 0; j < held.size(); j++) begin
      if (held[j] < idx) r = held[j];
    end
    return r;
  endfunction

  task automatic model_step();
    int a;
    int b;
    held.delete();
    for (int i = 0; i < NK; i++) begin
      if (keys[i]) held.push_back(i);
    end
    m_pulse = 1'b0;
    if (RESET) begin
      m_state  = M_BYP;
      m_cnt    = 0;
      m_idx    = 0;
      m_down   = 1'b0;
      m_lfsr   = 16'hACE1;
      m_key_on = '0;
    end else begin
      if (!enable) begin
        m_state = M_BYP;
        m_cnt   = 0;
        m_down  = 1'b0;
      end else if (m_state == M_BYP) begin
        m_state = M_IDLE;
      end else if (m_state == M_IDLE) begin
        if (held.size() > 0) begin
          m_state = M_PLAY;
          m_cnt   = 0;
          m_pulse = 1'b1;
          m_idx   = (mode == 2'd1) ? held[held.size() - 1] : held[0];
        end
      end else if (held.size() == 0) begin
        m_state = M_IDLE;
        m_cnt   = 0;
        m_down  = 1'b0;
      end else if (!keys[m_idx] || (m_cnt >= int'(step_len))) begin
        a = first_above(m_idx);
        b = last_below(m_idx);
        case (mode)
          2'd1: m_idx = (b >= 0) ? b : held[held.size() - 1];
          2'd2: begin
            if (!m_down) begin
              if (a >= 0) m_idx = a;
              else begin
                m_down = 1'b1;
                if (b >= 0) m_idx = b;
              end
            end else begin
              if (b >= 0) m_idx = b;
              else begin
                m_down = 1'b0;
                if (a >= 0) m_idx = a;
              end
            end
          end
`ifdef ARP_RANDOM_EN
          2'd3: m_idx = held[int'(m_lfsr) % held.size()];
`endif
          default: m_idx = (a >= 0) ? a : held[0];
        endcase
        m_cnt   = 0;
        m_pulse = 1'b1;
      end else begin
        m_cnt++;
      end
`ifdef ARP_RANDOM_EN
      if (m_pulse) m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
`endif
      m_key_on = '0;
      if (m_state == M_BYP) m_key_on = keys;
      else if ((m_state == M_PLAY) && (m_cnt < int'(gate_len))) m_key_on[m_idx] = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    check("key_on", 32'(key_on), 32'(m_key_on));
    check("step_pulse", 32'(step_pulse), 32'(m_pulse));
    check("cur_idx", 32'(cur_idx), 32'(m_idx));
    check("active", 32'(active), 32'(m_state == M_PLAY));
  endtask

  initial begin
    int up_seq[4];
    int pp_seq[8];
    int on_cnt;
    int pulse_cnt;
    int hits;

    up_seq = '{1, 4, 7, 1};
    pp_seq = '{0, 1, 2, 3, 2, 1, 0, 1};

    RESET    = 1'b1;
    enable   = 1'b0;
    mode     = 2'd0;
    step_len = '0;
    gate_len = '0;
    keys     = '0;
    tick();
    tick();
    check("rst_key_on", 32'(key_on), 32'h0);
    check("rst_pulse", 32'(step_pulse), 32'h0);
    check("rst_idx", 32'(cur_idx), 32'h0);
    check("rst_active", 32'(active), 32'h0);

    // Bypass
    RESET = 1'b0;
    keys  = 8'b0000_0101;
    tick();
    check("byp_key_on", 32'(key_on), 32'h05);
    check("byp_active", 32'(active), 32'h0);

    // Up order, 4-cycle steps, 2-cycle gate
    enable   = 1'b1;
    mode     = 2'd0;
    step_len = 16'd3;
    gate_len = 16'd2;
    keys     = 8'b1001_0010;
    tick();
    check("idle_key_on", 32'(key_on), 32'h0);
    on_cnt    = 0;
    pulse_cnt = 0;
    for (int t = 0; t < 16; t++) begin
      tick();
      check("up_idx", 32'(cur_idx), 32'(up_seq[t / 4]));
      if (key_on != '0) on_cnt++;
      if (step_pulse) pulse_cnt++;
    end
    check("up_gate_cycles", 32'(on_cnt), 32'd8);
    check("up_pulses", 32'(pulse_cnt), 32'd4);

    // Ping-pong, one step per cycle
    keys = '0;
    tick();
    mode     = 2'd2;
    step_len = 16'd0;
    keys     = 8'b0000_1111;
    for (int t = 0; t < 8; t++) begin
      tick();
      check("pp_idx", 32'(cur_idx), 32'(pp_seq[t]));
    end

    // Down order with current key released mid-step
    keys = '0;
    tick();
    mode     = 2'd1;
    step_len = 16'd9;
    gate_len = 16'd10;
    keys     = 8'b0011_0000;
    tick();
    check("down_entry_idx", 32'(cur_idx), 32'd5);
    repeat (4) tick();
    keys = 8'b0001_0000;
    tick();
    check("rel_key5_off", 32'(key_on[5]), 32'h0);
    check("rel_idx", 32'(cur_idx), 32'd4);
    check("rel_pulse", 32'(step_pulse), 32'h1);
    tick();
    check("rel_pulse_once", 32'(step_pulse), 32'h0);

    // Keys to zero, then disable, then reset mid-step
    keys = '0;
    tick();
    check("empty_active", 32'(active), 32'h0);
    check("empty_key_on", 32'(key_on), 32'h0);
    enable = 1'b0;
    keys   = 8'h21;
    tick();
    check("dis_key_on", 32'(key_on), 32'h21);
    enable   = 1'b1;
    mode     = 2'd0;
    step_len = 16'd5;
    gate_len = 16'd3;
    keys     = 8'h0F;
    repeat (4) tick();
    check("pre_rst_active", 32'(active), 32'h1);
    RESET = 1'b1;
    tick();
    check("mid_rst_key_on", 32'(key_on), 32'h0);
    check("mid_rst_active", 32'(active), 32'h0);
    check("mid_rst_pulse", 32'(step_pulse), 32'h0);
    check("mid_rst_idx", 32'(cur_idx), 32'h0);
    RESET = 1'b0;

    // Mode 3, all keys held
    mode     = 2'd3;
    step_len = 16'd0;
    gate_len = 16'd1;
    keys     = 8'hFF;
    tick();
    tick();
    hits = 0;
    for (int t = 0; t < 64; t++) begin
      tick();
      hits |= (1 << cur_idx);
    end
    check("rand_cover", 32'(hits), 32'hFF);

    // Random keys and modes
    for (int s = 0; s < 25; s++) begin
      enable   = 1'b0;
      step_len = CW'($urandom_range(0, 3));
      gate_len = CW'($urandom_range(0, 5));
      keys     = NK'($urandom);
      tick();
      enable = 1'b1;
      mode   = 2'($urandom_range(0, 3));
      for (int c = 0; c < 24; c++) begin
        if ($urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 4))
            0:       keys = '0;
            1:       keys = NK'(1) << $urandom_range(0, NK - 1);
            2:       keys = keys ^ (NK'(1) << $urandom_range(0, NK - 1));
            default: keys = NK'($urandom);
          endcase
        end
        if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
